// File: rtl/reservoir_pkg.sv
// Shared types and constants for the reservoir run sequencer.
package reservoir_pkg;

    // Sequencer phases; encodings 5..7 are unreachable and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_EVOLVE  = 3'd2,
        ST_DISABLE = 3'd3,
        ST_SETTLE  = 3'd4
    } seq_state_e;

    localparam int   RUN_IDX_W  = 8;
    // Leading bit sent ahead of every payload word.
    localparam logic MARKER_BIT = 1'b1;

    // Reservoir-side control levels held during a phase.
    typedef struct packed {
        logic res_enable;
        logic collect_dynamics;
        logic busy;
    } phase_ctl_t;

    function automatic phase_ctl_t phase_ctl(input seq_state_e st);
        phase_ctl_t ctl;
        ctl.res_enable       = 1'b0;
        ctl.collect_dynamics = 1'b0;
        ctl.busy             = 1'b0;
        case (st)
            ST_DRIVE, ST_EVOLVE: begin
                ctl.res_enable       = 1'b1;
                ctl.collect_dynamics = 1'b1;
                ctl.busy             = 1'b1;
            end
            ST_DISABLE: begin
                ctl.busy = 1'b1;
            end
            ST_SETTLE: begin
                ctl.res_enable = 1'b1;
                ctl.busy       = 1'b1;
            end
            default: begin
                ctl.res_enable       = 1'b0;
                ctl.collect_dynamics = 1'b0;
                ctl.busy             = 1'b0;
            end
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/reservoir_sequencer_if.sv
// Request/status bundle between a controller and the reservoir sequencer.
interface reservoir_sequencer_if #(
    parameter int IN_BITS = 7
);
    import reservoir_pkg::*;

    logic                 acquire;
    logic                 abort;
    logic [IN_BITS-1:0]   word_in;
    logic                 in_state;
    logic                 res_enable;
    logic                 collect_dynamics;
    logic                 busy;
    logic                 done;
    logic [RUN_IDX_W-1:0] run_idx;

    modport master (
        output acquire, abort, word_in,
        input  in_state, res_enable, collect_dynamics, busy, done, run_idx
    );

    modport slave (
        input  acquire, abort, word_in,
        output in_state, res_enable, collect_dynamics, busy, done, run_idx
    );

endinterface

// File: rtl/input_serializer.sv
// Frame shifter: marker bit first, then the payload LSB first, then zeros.
module input_serializer
    import reservoir_pkg::*;
#(
    parameter int IN_BITS = 7
) (
    input  logic               fast_clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic               shift,
    input  logic [IN_BITS-1:0] word,
    output logic               serial_out
);

    logic [IN_BITS:0] shreg_r;

    // Frame register; clear beats load beats shift, and emptied bits fill with 0.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            shreg_r <= {(IN_BITS+1){1'b0}};
        end else if (clear) begin
            shreg_r <= {(IN_BITS+1){1'b0}};
        end else if (load) begin
            shreg_r <= {word, MARKER_BIT};
        end else if (shift) begin
            shreg_r <= {1'b0, shreg_r[IN_BITS:1]};
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign serial_out = shreg_r[0];

endmodule

// File: rtl/reservoir_sequencer.sv
// Sequences drive / evolve / disable / settle phases of a reservoir run.
module reservoir_sequencer
    import reservoir_pkg::*;
#(
    parameter int IN_BITS     = 7,
    parameter int EVOLVE_CYC  = 2994,
    parameter int DISABLE_CYC = 100,
    parameter int SETTLE_CYC  = 100,
    parameter int N_RUNS      = 1,
    parameter int CNT_W       = 12
) (
    input logic                  fast_clk,
    input logic                  reset,
    reservoir_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX_C     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DRIVE_LAST_C  = CNT_W'(IN_BITS);
    localparam logic [CNT_W-1:0] EVOLVE_LAST_C = CNT_W'((EVOLVE_CYC > 0) ? EVOLVE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] DIS_LAST_C    = CNT_W'((DISABLE_CYC > 0) ? DISABLE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST_C = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [RUN_IDX_W-1:0] LAST_RUN_C = RUN_IDX_W'(N_RUNS - 1);

    // Successor of each phase with empty phases skipped; ST_IDLE marks run end.
    localparam seq_state_e FROM_DISABLE_C = (SETTLE_CYC > 0)  ? ST_SETTLE  : ST_IDLE;
    localparam seq_state_e FROM_EVOLVE_C  = (DISABLE_CYC > 0) ? ST_DISABLE : FROM_DISABLE_C;
    localparam seq_state_e FROM_DRIVE_C   = (EVOLVE_CYC > 0)  ? ST_EVOLVE  : FROM_EVOLVE_C;

    seq_state_e           state_r;
    seq_state_e           next_state_s;
    seq_state_e           phase_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [RUN_IDX_W-1:0] run_idx_r;
    logic [IN_BITS-1:0]   word_r;
    logic [IN_BITS-1:0]   ser_word_s;
    logic                 phase_end_s;
    logic                 load_s;
    logic                 shift_s;
    logic                 clear_s;
    logic                 done_s;
    logic                 run_inc_s;
    logic                 capture_s;
    logic                 cnt_clr_s;
    logic                 in_state_s;
    logic                 res_enable_r;
    logic                 collect_r;
    logic                 busy_r;
    logic                 done_r;
    phase_ctl_t           next_ctl_s;

    // Detect the last cycle of the current phase and where it leads.
    always_comb begin
        phase_end_s  = 1'b0;
        phase_next_s = ST_IDLE;
        case (state_r)
            ST_DRIVE: begin
                phase_end_s  = (cnt_r == DRIVE_LAST_C);
                phase_next_s = FROM_DRIVE_C;
            end
            ST_EVOLVE: begin
                phase_end_s  = (cnt_r == EVOLVE_LAST_C);
                phase_next_s = FROM_EVOLVE_C;
            end
            ST_DISABLE: begin
                phase_end_s  = (cnt_r == DIS_LAST_C);
                phase_next_s = FROM_DISABLE_C;
            end
            ST_SETTLE: begin
                phase_end_s  = (cnt_r == SETTLE_LAST_C);
                phase_next_s = ST_IDLE;
            end
            default: begin
                phase_end_s  = 1'b0;
                phase_next_s = ST_IDLE;
            end
        endcase
    end

    // Next-state decode; abort outranks a phase end, acquire counts only in IDLE.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        clear_s      = 1'b0;
        done_s       = 1'b0;
        run_inc_s    = 1'b0;
        capture_s    = 1'b0;
        cnt_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                if (bus.acquire && !bus.abort) begin
                    next_state_s = ST_DRIVE;
                    load_s       = 1'b1;
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRIVE, ST_EVOLVE, ST_DISABLE, ST_SETTLE: begin
                if (bus.abort) begin
                    next_state_s = ST_IDLE;
                    clear_s      = 1'b1;
                    cnt_clr_s    = 1'b1;
                end else begin
                    shift_s = (state_r == ST_DRIVE);
                    if (!phase_end_s) begin
                        next_state_s = state_r;
                    end else if (phase_next_s != ST_IDLE) begin
                        next_state_s = phase_next_s;
                        cnt_clr_s    = 1'b1;
                    end else if (run_idx_r != LAST_RUN_C) begin
                        next_state_s = ST_DRIVE;
                        load_s       = 1'b1;
                        run_inc_s    = 1'b1;
                        cnt_clr_s    = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                        done_s       = 1'b1;
                        clear_s      = 1'b1;
                        cnt_clr_s    = 1'b1;
                    end
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                clear_s      = 1'b1;
                cnt_clr_s    = 1'b1;
            end
        endcase
    end

    // Fresh runs take the incoming word; repeat runs replay the captured copy.
    always_comb begin
        if (capture_s) begin
            ser_word_s = bus.word_in;
        end else begin
            ser_word_s = word_r;
        end
    end

    assign next_ctl_s = phase_ctl(next_state_s);

    // State, phase counter, run index, captured word and registered controls.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            run_idx_r    <= {RUN_IDX_W{1'b0}};
            word_r       <= {IN_BITS{1'b0}};
            res_enable_r <= 1'b0;
            collect_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (cnt_clr_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r != CNT_MAX_C) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            if (run_inc_s) begin
                run_idx_r <= run_idx_r + 8'd1;
            end else if (capture_s || next_state_s == ST_IDLE) begin
                run_idx_r <= {RUN_IDX_W{1'b0}};
            end else begin
                run_idx_r <= run_idx_r;
            end
            if (capture_s) begin
                word_r <= bus.word_in;
            end else begin
                word_r <= word_r;
            end
            res_enable_r <= next_ctl_s.res_enable;
            collect_r    <= next_ctl_s.collect_dynamics;
            busy_r       <= next_ctl_s.busy;
            done_r       <= done_s;
        end
    end

    input_serializer #(
        .IN_BITS(IN_BITS)
    ) u_serializer (
        .fast_clk  (fast_clk),
        .reset     (reset),
        .clear     (clear_s),
        .load      (load_s),
        .shift     (shift_s),
        .word      (ser_word_s),
        .serial_out(in_state_s)
    );

    assign bus.in_state         = in_state_s;
    assign bus.res_enable       = res_enable_r;
    assign bus.collect_dynamics = collect_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.run_idx          = run_idx_r;

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Randomized and directed bench for reservoir_sequencer against a sequence model.
module tb_reservoir_sequencer;

    localparam int A_BITS = 7, A_EVO = 12, A_DIS = 3, A_SET = 2, A_RUNS = 3;
    localparam int B_BITS = 5, B_EVO = 4,  B_DIS = 0, B_SET = 2, B_RUNS = 1;
    localparam int A_TOTAL = A_RUNS * (A_BITS + 1 + A_EVO + A_DIS + A_SET);
    localparam int B_TOTAL = B_RUNS * (B_BITS + 1 + B_EVO + B_DIS + B_SET);

    typedef struct packed {
        logic       in_state;
        logic       res_enable;
        logic       collect;
        logic       busy;
        logic       done;
        logic [7:0] run_idx;
    } outs_t;

    // One expected output cycle plus its phase (0 drive .. 3 settle, 4 done) and position.
    typedef struct packed {
        outs_t       o;
        logic [2:0]  phase;
        logic [15:0] pos;
    } ent_t;

    logic        fast_clk = 1'b0;
    logic        reset    = 1'b0;
    logic        acq      = 1'b0;
    logic        abt      = 1'b0;
    logic [31:0] word     = 32'd0;

    ent_t qa[$];
    ent_t qb[$];
    ent_t cur_a;
    ent_t cur_b;
    int   n_checks = 0;
    int   n_pass   = 0;

    reservoir_sequencer_if #(.IN_BITS(A_BITS)) bus_a ();
    reservoir_sequencer_if #(.IN_BITS(B_BITS)) bus_b ();

    assign bus_a.acquire = acq;
    assign bus_a.abort   = abt;
    assign bus_a.word_in = word[A_BITS-1:0];
    assign bus_b.acquire = acq;
    assign bus_b.abort   = abt;
    assign bus_b.word_in = word[B_BITS-1:0];

    reservoir_sequencer #(
        .IN_BITS(A_BITS), .EVOLVE_CYC(A_EVO), .DISABLE_CYC(A_DIS),
        .SETTLE_CYC(A_SET), .N_RUNS(A_RUNS), .CNT_W(12)
    ) dut_a (.fast_clk(fast_clk), .reset(reset), .bus(bus_a));

    reservoir_sequencer #(
        .IN_BITS(B_BITS), .EVOLVE_CYC(B_EVO), .DISABLE_CYC(B_DIS),
        .SETTLE_CYC(B_SET), .N_RUNS(B_RUNS), .CNT_W(8)
    ) dut_b (.fast_clk(fast_clk), .reset(reset), .bus(bus_b));

    // Free-running clock.
    always #5 fast_clk = ~fast_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic ins, input logic en, input logic col, input logic bsy,
                                input logic dn, input int run, input int ph, input int pos);
        ent_t e;
        e.o.in_state   = ins;
        e.o.res_enable = en;
        e.o.collect    = col;
        e.o.busy       = bsy;
        e.o.done       = dn;
        e.o.run_idx    = 8'(run);
        e.phase        = 3'(ph);
        e.pos          = 16'(pos);
        return e;
    endfunction

    // Whole expected acquisition, written straight from the phase rules.
    task automatic build(input int bits, input int evo, input int dis, input int set,
                         input int runs, input logic [31:0] w, output ent_t q[$]);
        q.delete();
        for (int r = 0; r < runs; r++) begin
            q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, r, 0, 0));
            for (int b = 0; b < bits; b++) q.push_back(mk(w[b], 1'b1, 1'b1, 1'b1, 1'b0, r, 0, b + 1));
            for (int e = 0; e < evo; e++)  q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, r, 1, e));
            for (int d = 0; d < dis; d++)  q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r, 2, d));
            for (int s = 0; s < set; s++)  q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, r, 3, s));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, 0));
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        cur_a = '0;
        cur_b = '0;
    endtask

    // Advance both models by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            if (cur_a.o.busy) begin
                if (abt) begin qa.delete(); cur_a = '0; end
                else cur_a = qa.pop_front();
            end else if (acq && !abt) begin
                build(A_BITS, A_EVO, A_DIS, A_SET, A_RUNS, word, qa);
                cur_a = qa.pop_front();
            end else begin
                cur_a = '0;
            end
            if (cur_b.o.busy) begin
                if (abt) begin qb.delete(); cur_b = '0; end
                else cur_b = qb.pop_front();
            end else if (acq && !abt) begin
                build(B_BITS, B_EVO, B_DIS, B_SET, B_RUNS, word, qb);
                cur_b = qb.pop_front();
            end else begin
                cur_b = '0;
            end
        end
    endtask

    function automatic outs_t outs_a();
        return {bus_a.in_state, bus_a.res_enable, bus_a.collect_dynamics, bus_a.busy, bus_a.done, bus_a.run_idx};
    endfunction

    function automatic outs_t outs_b();
        return {bus_b.in_state, bus_b.res_enable, bus_b.collect_dynamics, bus_b.busy, bus_b.done, bus_b.run_idx};
    endfunction

    task automatic compare_outs();
        check_eq("A_outs", 32'(outs_a()), 32'(cur_a.o));
        check_eq("B_outs", 32'(outs_b()), 32'(cur_b.o));
    endtask

    task automatic tick();
        @(posedge fast_clk);
        model_edge();
        #1;
        compare_outs();
    endtask

    // Single acquire of 7'b0101101 with directed measurements of pattern and latency.
    task automatic run_measure(input string tag);
        logic [7:0] seq;
        logic [2:0] runs_a;
        logic       b_drop;
        int         lat_a, lat_b, dones_a;
        seq = 8'd0; runs_a = 3'd0; b_drop = 1'b0;
        lat_a = -1; lat_b = -1; dones_a = 0;
        word = 32'h0000_002D;
        acq  = 1'b1;
        tick();
        acq = 1'b0;
        seq[0] = bus_a.in_state;
        for (int c = 1; c <= 80; c++) begin
            if (c % 5 == 0) word = $urandom;
            tick();
            if (c < 8) seq[c] = bus_a.in_state;
            if (bus_a.busy && bus_a.run_idx < 8'd3) runs_a[bus_a.run_idx[1:0]] = 1'b1;
            if (bus_a.done) begin dones_a++; lat_a = c; end
            if (bus_b.done) lat_b = c;
            if (bus_b.busy && !bus_b.res_enable) b_drop = 1'b1;
        end
        check_eq({tag, "_drive_seq"}, 32'(seq), 32'h5B);
        check_eq({tag, "_done_lat_a"}, lat_a, A_TOTAL);
        check_eq({tag, "_done_lat_b"}, lat_b, B_TOTAL);
        check_eq({tag, "_done_count_a"}, dones_a, 1);
        check_eq({tag, "_runs_seen_a"}, 32'(runs_a), 32'h7);
        check_eq({tag, "_b_enable_held"}, 32'(b_drop), 32'h0);
    endtask

    initial begin
        bit found;
        int n_done;
        int held_lat;
        model_reset();

        // Asynchronous reset before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_eq("reset_async_a", 32'(outs_a()), 32'h0);
        check_eq("reset_async_b", 32'(outs_b()), 32'h0);
        repeat (3) tick();
        #2 reset = 1'b0;
        repeat (2) tick();

        run_measure("first");

        // Abort at EVOLVE count 10 on the 3-run instance.
        acq = 1'b1;
        tick();
        acq = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (cur_a.o.busy && cur_a.phase == 3'd1 && cur_a.pos == 16'd10) found = 1'b1;
        end
        check_eq("abort_reach", 32'(found), 32'h1);
        abt = 1'b1;
        tick();
        abt = 1'b0;
        check_eq("abort_idle_a", 32'(outs_a()), 32'h0);
        n_done = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus_a.done) n_done++;
        end
        check_eq("abort_no_done", n_done, 0);

        // Acquire held through a whole acquisition, restart right after done.
        acq = 1'b1;
        tick();
        held_lat = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (bus_a.done) begin held_lat = c; break; end
        end
        check_eq("held_done_lat", held_lat, A_TOTAL);
        check_eq("held_done_idle", 32'(bus_a.busy), 32'h0);
        tick();
        check_eq("restart_busy", 32'(bus_a.busy), 32'h1);
        check_eq("restart_run_idx", 32'(bus_a.run_idx), 32'h0);
        acq = 1'b0;
        abt = 1'b1;
        tick();
        abt = 1'b0;
        tick();

        // Reset pulse during DISABLE, then a clean full acquisition.
        acq = 1'b1;
        tick();
        acq = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (cur_a.o.busy && cur_a.phase == 3'd2) found = 1'b1;
        end
        check_eq("disable_reach", 32'(found), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("reset_mid_a", 32'(outs_a()), 32'h0);
        check_eq("reset_mid_b", 32'(outs_b()), 32'h0);
        tick();
        #2 reset = 1'b0;
        tick();
        run_measure("after_reset");

        // Random acquire/abort traffic with a changing word.
        for (int c = 0; c < 2000; c++) begin
            acq  = ($urandom_range(7) == 0);
            abt  = ($urandom_range(63) == 0);
            word = $urandom;
            tick();
        end
        acq = 1'b0;
        abt = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reservoir_sequencer.md
RESERVOIR_SEQUENCER -- requirements
Module: reservoir_sequencer

Interface
REQ-001 The block SHALL have parameter IN_BITS, default 7, meaning payload bits per run, in range 1..32.
REQ-002 The block SHALL have parameter EVOLVE_CYC, default 2994, meaning enabled free-evolution cycles after drive.
REQ-003 The block SHALL have parameter DISABLE_CYC, default 100, meaning cycles with reservoir disabled to settle.
REQ-004 The block SHALL have parameter SETTLE_CYC, default 100, meaning re-enabled cycles before run end.
REQ-005 The block SHALL have parameter N_RUNS, default 1, meaning repeats of the same word per acquisition, in range 1..255.
REQ-006 The block SHALL have parameter CNT_W, default 12, meaning phase-counter width; each *_CYC SHALL be at most 2^CNT_W-1.
REQ-007 The block SHALL have port fast_clk, input, 1, clock.
REQ-008 The block SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-009 The block SHALL have port acquire, input, 1, start request, sampled in IDLE only.
REQ-010 The block SHALL have port abort, input, 1, synchronous run cancel.
REQ-011 The block SHALL have port word_in, input, IN_BITS, payload captured on accepted acquire.
REQ-012 The block SHALL have port in_state, output, 1, serial drive into reservoir.
REQ-013 The block SHALL have port res_enable, output, 1, reservoir enable.
REQ-014 The block SHALL have port collect_dynamics, output, 1, sampling window for downstream capture.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1, single-cycle pulse after the final run completes.
REQ-017 The block SHALL have port run_idx, output, 8, index of the current run, zero-based.

Function
REQ-018 All outputs SHALL be registered; the states SHALL be IDLE, DRIVE, EVOLVE, DISABLE, SETTLE.
REQ-019 IDLE with acquire=1 and abort=0 SHALL capture word_in, clear run_idx and the counter, and enter DRIVE on the same edge.
REQ-020 DRIVE SHALL last IN_BITS+1 cycles; in_state SHALL be 1 (marker) in the first cycle, then word bit 0, 1, ... IN_BITS-1, LSB first.
REQ-021 In DRIVE, res_enable=1 and collect_dynamics=1.
REQ-022 EVOLVE SHALL last EVOLVE_CYC cycles with in_state=0, res_enable=1, collect_dynamics=1.
REQ-023 DISABLE SHALL last DISABLE_CYC cycles with in_state=0, res_enable=0, collect_dynamics=0.
REQ-024 SETTLE SHALL last SETTLE_CYC cycles with in_state=0, res_enable=1, collect_dynamics=0.
REQ-025 At the end of SETTLE, if run_idx<N_RUNS-1, run_idx SHALL increment and the block SHALL re-enter DRIVE with the captured word; otherwise it SHALL enter IDLE with done=1 for exactly that one cycle.
REQ-026 A *_CYC value of 0 SHALL skip that phase with no dead cycle.
REQ-027 In IDLE, in_state, res_enable, collect_dynamics and busy SHALL all be 0.
REQ-028 acquire SHALL be ignored while busy=1; word_in changes during a run SHALL have no effect.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with all outputs 0 and no done pulse; abort SHALL take priority over a phase end.
REQ-030 acquire and abort both high in IDLE SHALL leave the block in IDLE.
REQ-031 The counter SHALL never wrap; it SHALL clear on every phase change.
REQ-032 An unreachable state encoding SHALL return the block to IDLE with outputs 0.

Reset
REQ-033 While reset=1, state SHALL be IDLE and every output, the counter, run_idx and the captured word SHALL be 0, independent of fast_clk.
REQ-034 Reset asserted mid-run SHALL abandon the run without a done pulse; the first acquire after release SHALL start cleanly.

Structure
REQ-035 The state enum, the 8-bit run_idx width and the marker constant SHALL live in the shared package reservoir_pkg.
REQ-036 The block SHALL have one sub-module, input_serializer (load, shift, LSB-first with leading marker), instantiated once.
REQ-037 The PLL SHALL stay outside this block; fast_clk SHALL be supplied by the parent.

Verification
REQ-038 IN_BITS=7, word 7'b0101101, acquire pulse -> in_state sequence 1,1,0,1,1,0,1,0, then EVOLVE begins; done fires 8+EVOLVE_CYC+DISABLE_CYC+SETTLE_CYC cycles after acceptance.
REQ-039 N_RUNS=3, short phases (4/2/2) -> run_idx 0,1,2, identical drive pattern each run, exactly one done pulse.
REQ-040 abort during EVOLVE at count 10 -> IDLE on the next edge, all outputs 0, no done pulse.
REQ-041 acquire held high for a whole run -> exactly one run completes; a new run starts the cycle after done.
REQ-042 reset pulsed during DISABLE -> outputs 0 asynchronously; the next acquire gives the full correct sequence.
REQ-043 DISABLE_CYC=0 -> res_enable never drops between EVOLVE and SETTLE.
